// File: rtl/hanoi_pkg.sv
// Shared definitions for the Towers of Hanoi move checker.
// Peg codes, error codes and FSM states used by the checker and its top-disk finder.
// Disk indices are IDX_W bits wide, enough for up to 8 disks.
package hanoi_pkg;

  localparam logic [1:0] PEG_NONE = 2'd0;
  localparam logic [1:0] PEG_A    = 2'd1;
  localparam logic [1:0] PEG_B    = 2'd2;
  localparam logic [1:0] PEG_C    = 2'd3;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PEG   = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_SIZE  = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SOLVED = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

endpackage

// File: rtl/hanoi_top_finder.sv
// Finds the top (smallest, lowest-index) disk sitting on one peg.
// Purely combinational from disk_loc; zero latency.
// No flow control: result is valid whenever disk_loc and peg are.
module hanoi_top_finder
  import hanoi_pkg::*;
#(
  parameter int N_DISKS = 5
) (
  input  logic [2*N_DISKS-1:0] disk_loc,
  input  logic [1:0]           peg,
  output logic [IDX_W-1:0]     top,
  output logic                 empty
);

  // Scan from the largest disk down so the smallest disk on the peg is the last writer.
  always_comb begin
    top   = '0;
    empty = 1'b1;
    for (int i = N_DISKS - 1; i >= 0; i--) begin
      if (disk_loc[2*i +: 2] == peg) begin
        top   = IDX_W'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hanoi_checker.sv
// Checks a stream of Towers of Hanoi moves, tracking every disk's peg in disk_loc.
// A legal move updates disk_loc/move_count on the accepting edge (visible next cycle).
// move_ready drops in SOLVED/ERROR; only init or reset return the checker to ACTIVE.
module hanoi_checker
  import hanoi_pkg::*;
#(
  parameter int         N_DISKS    = 5,
  parameter logic [1:0] TARGET_PEG = PEG_C
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 move_valid,
  input  logic [1:0]           from_peg,
  input  logic [1:0]           to_peg,
  output logic                 move_ready,
  output logic                 solved,
  output logic                 illegal,
  output logic [1:0]           err_code,
  output logic [N_DISKS:0]     move_count,
  output logic [2*N_DISKS-1:0] disk_loc
);

  localparam logic [2*N_DISKS-1:0] START_LOC  = {N_DISKS{PEG_A}};
  localparam logic [2*N_DISKS-1:0] SOLVED_LOC = {N_DISKS{TARGET_PEG}};
  localparam logic [N_DISKS:0]     CNT_ONE    = (N_DISKS + 1)'(1);

  state_e state, state_nxt;
  err_e   err_q, move_err;

  logic [IDX_W-1:0] top_a, top_b, top_c, src_top, dst_top;
  logic             empty_a, empty_b, empty_c, src_empty, dst_empty;
  logic             accept;
  logic [2*N_DISKS-1:0] loc_nxt;

  hanoi_top_finder #(.N_DISKS(N_DISKS)) u_top_a (
    .disk_loc (disk_loc), .peg (PEG_A), .top (top_a), .empty (empty_a)
  );
  hanoi_top_finder #(.N_DISKS(N_DISKS)) u_top_b (
    .disk_loc (disk_loc), .peg (PEG_B), .top (top_b), .empty (empty_b)
  );
  hanoi_top_finder #(.N_DISKS(N_DISKS)) u_top_c (
    .disk_loc (disk_loc), .peg (PEG_C), .top (top_c), .empty (empty_c)
  );

  // Route the per-peg top-disk results to the move's source and destination.
  always_comb begin
    src_top   = '0;
    src_empty = 1'b1;
    dst_top   = '0;
    dst_empty = 1'b1;
    case (from_peg)
      PEG_A:   begin src_top = top_a; src_empty = empty_a; end
      PEG_B:   begin src_top = top_b; src_empty = empty_b; end
      PEG_C:   begin src_top = top_c; src_empty = empty_c; end
      default: begin src_top = '0;    src_empty = 1'b1;    end
    endcase
    case (to_peg)
      PEG_A:   begin dst_top = top_a; dst_empty = empty_a; end
      PEG_B:   begin dst_top = top_b; dst_empty = empty_b; end
      PEG_C:   begin dst_top = top_c; dst_empty = empty_c; end
      default: begin dst_top = '0;    dst_empty = 1'b1;    end
    endcase
  end

  // Classify the presented move; earlier checks take priority over later ones.
  always_comb begin
    move_err = ERR_NONE;
    if (from_peg == PEG_NONE || to_peg == PEG_NONE || from_peg == to_peg)
      move_err = ERR_PEG;
    else if (src_empty)
      move_err = ERR_EMPTY;
    else if (!dst_empty && dst_top < src_top)
      move_err = ERR_SIZE;
  end

  // Peg map after the move: only the source's top disk changes peg.
  always_comb begin
    loc_nxt = disk_loc;
    for (int i = 0; i < N_DISKS; i++) begin
      if (IDX_W'(i) == src_top)
        loc_nxt[2*i +: 2] = to_peg;
    end
  end

  // A move coinciding with init is dropped; reset priority is handled in the registers.
  assign accept = move_valid && move_ready && !init;

  // Datapath registers: peg map, legal-move counter and first error code.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      disk_loc   <= START_LOC;
      move_count <= '0;
      err_q      <= ERR_NONE;
    end else if (accept) begin
      if (move_err == ERR_NONE) begin
        disk_loc <= loc_nxt;
        if (move_count != '1)
          move_count <= move_count + CNT_ONE;
      end else begin
        err_q <= move_err;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_ACTIVE;
    else
      state <= state_nxt;
  end

  // FSM next state: init always restarts; ERROR and SOLVED otherwise hold.
  always_comb begin
    state_nxt = state;
    if (init)
      state_nxt = ST_ACTIVE;
    else if (state == ST_ACTIVE && accept) begin
      if (move_err != ERR_NONE)
        state_nxt = ST_ERROR;
      else if (loc_nxt == SOLVED_LOC)
        state_nxt = ST_SOLVED;
    end
  end

  // FSM outputs.
  always_comb begin
    move_ready = (state == ST_ACTIVE);
    solved     = (state == ST_SOLVED);
    illegal    = (state == ST_ERROR);
    err_code   = err_q;
  end

endmodule

// File: tb/tb_hanoi_checker.sv
// Self-checking bench for hanoi_checker: directed scenarios plus randomized moves vs a stack model.
// Three instances (3 disks, 5 disks, 1 disk with target peg 1) share one stimulus bus.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hanoi_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, init, move_valid;
  logic [1:0] from_peg, to_peg;

  logic       ready3, solved3, illegal3;
  logic [1:0] err3;
  logic [3:0] cnt3;
  logic [5:0] loc3;

  logic       ready5, solved5, illegal5;
  logic [1:0] err5;
  logic [5:0] cnt5;
  logic [9:0] loc5;

  logic       ready1, solved1, illegal1;
  logic [1:0] err1;
  logic [1:0] cnt1;
  logic [1:0] loc1;

  hanoi_checker #(.N_DISKS(3), .TARGET_PEG(2'd3)) dut3 (
    .clk(clk), .reset(reset), .init(init), .move_valid(move_valid),
    .from_peg(from_peg), .to_peg(to_peg), .move_ready(ready3), .solved(solved3),
    .illegal(illegal3), .err_code(err3), .move_count(cnt3), .disk_loc(loc3)
  );
  hanoi_checker #(.N_DISKS(5)) dut5 (
    .clk(clk), .reset(reset), .init(init), .move_valid(move_valid),
    .from_peg(from_peg), .to_peg(to_peg), .move_ready(ready5), .solved(solved5),
    .illegal(illegal5), .err_code(err5), .move_count(cnt5), .disk_loc(loc5)
  );
  hanoi_checker #(.N_DISKS(1), .TARGET_PEG(2'd1)) dut1 (
    .clk(clk), .reset(reset), .init(init), .move_valid(move_valid),
    .from_peg(from_peg), .to_peg(to_peg), .move_ready(ready1), .solved(solved1),
    .illegal(illegal1), .err_code(err1), .move_count(cnt1), .disk_loc(loc1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for the 5-disk instance: each peg is a stack, back() is the top disk.
  int stk[4][$];
  int m_cnt;
  bit m_ill;
  bit m_sol;
  int m_err;

  task automatic model_load();
    for (int p = 0; p < 4; p++) stk[p].delete();
    for (int d = 4; d >= 0; d--) stk[1].push_back(d);
    m_cnt = 0; m_ill = 0; m_sol = 0; m_err = 0;
  endtask

  task automatic model_move(input int f, input int t);
    int d;
    if (m_ill || m_sol) return;
    if (f == 0 || t == 0 || f == t) begin
      m_ill = 1; m_err = 1;
    end else if (stk[f].size() == 0) begin
      m_ill = 1; m_err = 2;
    end else if (stk[t].size() != 0 && stk[t][stk[t].size()-1] < stk[f][stk[f].size()-1]) begin
      m_ill = 1; m_err = 3;
    end else begin
      d = stk[f].pop_back();
      stk[t].push_back(d);
      if (m_cnt < 63) m_cnt++;
      if (stk[3].size() == 5) m_sol = 1;
    end
  endtask

  function automatic logic [9:0] model_loc();
    logic [9:0] loc = '0;
    for (int p = 1; p <= 3; p++)
      for (int k = 0; k < stk[p].size(); k++)
        loc[2*stk[p][k] +: 2] = 2'(p);
    return loc;
  endfunction

  // Move k (1-based) of the optimal solution; for an odd disk count it ends on peg 3.
  function automatic logic [3:0] opt_move(input int k);
    logic [1:0] f, t;
    f = 2'(((k & (k - 1)) % 3) + 1);
    t = 2'((((k | (k - 1)) + 1) % 3) + 1);
    return {f, t};
  endfunction

  task automatic drive(input logic r, input logic i, input logic v,
                       input logic [1:0] f, input logic [1:0] t);
    reset = r; init = i; move_valid = v; from_peg = f; to_peg = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (loc3 !== 6'h15) begin errors++; $display("FAIL reset_loc3 got %h want 15", loc3); end
    checks++; if (loc5 !== 10'h155) begin errors++; $display("FAIL reset_loc5 got %h want 155", loc5); end
    checks++; if (cnt3 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt3); end
    checks++; if ({ready3, solved3, illegal3, err3} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got %b want 10000", {ready3, solved3, illegal3, err3});
    end
    checks++; if (solved1 !== 1'b0) begin errors++; $display("FAIL reset_solved_t1 got %b want 0", solved1); end
  endtask

  task automatic test_solve3();
    logic [3:0] mv;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      mv = opt_move(k);
      drive(1'b0, 1'b0, 1'b1, mv[3:2], mv[1:0]);
      if (k == 6) begin
        checks++; if (solved3 !== 1'b0) begin errors++; $display("FAIL solve3_early got %b want 0", solved3); end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++; if (solved3 !== 1'b1) begin errors++; $display("FAIL solve3_solved got %b want 1", solved3); end
    checks++; if (cnt3 !== 4'd7) begin errors++; $display("FAIL solve3_cnt got %0d want 7", cnt3); end
    checks++; if (illegal3 !== 1'b0) begin errors++; $display("FAIL solve3_illegal got %b want 0", illegal3); end
    checks++; if (loc3 !== 6'h3f) begin errors++; $display("FAIL solve3_loc got %h want 3f", loc3); end
    checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL solve3_ready got %b want 0", ready3); end
  endtask

  task automatic test_errors();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
    checks++; if ({illegal3, err3} !== 3'b111) begin errors++; $display("FAIL size_err got %b want 111", {illegal3, err3}); end
    checks++; if (cnt3 !== 4'd1) begin errors++; $display("FAIL size_cnt got %0d want 1", cnt3); end
    checks++; if (loc3[1:0] !== 2'd3) begin errors++; $display("FAIL size_loc got %0d want 3", loc3[1:0]); end
    // Further moves while in ERROR must not change anything, including err_code.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd2);
    checks++; if ({err3, cnt3, ready3} !== {2'd3, 4'd1, 1'b0}) begin
      errors++; $display("FAIL err_sticky got %b want %b", {err3, cnt3, ready3}, {2'd3, 4'd1, 1'b0});
    end

    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    checks++; if (err3 !== 2'd2) begin errors++; $display("FAIL empty_err got %0d want 2", err3); end
    checks++; if (loc3 !== 6'h15) begin errors++; $display("FAIL empty_loc got %h want 15", loc3); end

    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
    checks++; if (err3 !== 2'd1) begin errors++; $display("FAIL peg0_err got %0d want 1", err3); end

    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
    checks++; if (err3 !== 2'd1) begin errors++; $display("FAIL same_peg_err got %0d want 1", err3); end

    // 3->3 also fails the empty check; the peg check has priority.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 2'd3);
    checks++; if (err3 !== 2'd1) begin errors++; $display("FAIL priority_err got %0d want 1", err3); end
  endtask

  task automatic test_init();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
    checks++; if (illegal3 !== 1'b1) begin errors++; $display("FAIL init_pre_illegal got %b want 1", illegal3); end
    drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd3);
    checks++; if ({cnt3, illegal3, ready3, err3} !== {4'd0, 1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL init_state got %b want %b", {cnt3, illegal3, ready3, err3}, {4'd0, 1'b0, 1'b1, 2'd0});
    end
    checks++; if (loc3 !== 6'h15) begin errors++; $display("FAIL init_loc got %h want 15", loc3); end
    drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
    checks++; if (cnt3 !== 4'd1 || loc3 !== 6'h17) begin
      errors++; $display("FAIL init_next_move got cnt %0d loc %h want cnt 1 loc 17", cnt3, loc3);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k[0]) drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd1);
      else      drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd2);
      if (k == 13) begin
        checks++; if (cnt3 !== 4'd14) begin errors++; $display("FAIL sat_before got %0d want 14", cnt3); end
      end
    end
    checks++; if (cnt3 !== 4'd15) begin errors++; $display("FAIL sat_cnt3 got %0d want 15", cnt3); end
    checks++; if (cnt5 !== 6'd20) begin errors++; $display("FAIL sat_cnt5 got %0d want 20", cnt5); end
    checks++; if (illegal3 !== 1'b0) begin errors++; $display("FAIL sat_illegal got %b want 0", illegal3); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] mv;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      mv = opt_move(k);
      drive(1'b0, 1'b0, 1'b1, mv[3:2], mv[1:0]);
    end
    checks++; if (cnt5 !== 6'd10) begin errors++; $display("FAIL mid_cnt got %0d want 10", cnt5); end
    mv = opt_move(11);
    drive(1'b1, 1'b0, 1'b1, mv[3:2], mv[1:0]);
    checks++; if (loc5 !== 10'h155 || cnt5 !== 6'd0) begin
      errors++; $display("FAIL mid_reset got loc %h cnt %0d want loc 155 cnt 0", loc5, cnt5);
    end
    for (int k = 1; k <= 31; k++) begin
      mv = opt_move(k);
      drive(1'b0, 1'b0, 1'b1, mv[3:2], mv[1:0]);
    end
    checks++; if (solved5 !== 1'b1 || cnt5 !== 6'd31) begin
      errors++; $display("FAIL replay got solved %b cnt %0d want solved 1 cnt 31", solved5, cnt5);
    end
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1, 2'd3, 2'd1);
    checks++; if ({cnt5, loc5, solved5, illegal5} !== {6'd31, 10'h3ff, 1'b1, 1'b0}) begin
      errors++; $display("FAIL solved_hold got %h want %h", {cnt5, loc5, solved5, illegal5}, {6'd31, 10'h3ff, 1'b1, 1'b0});
    end
  endtask

  task automatic test_target1();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 2'd1, 2'd2);
    checks++; if (solved1 !== 1'b0 || cnt1 !== 2'd1) begin
      errors++; $display("FAIL t1_away got solved %b cnt %0d want 0 1", solved1, cnt1);
    end
    drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd1);
    checks++; if (solved1 !== 1'b1 || loc1 !== 2'd1) begin
      errors++; $display("FAIL t1_back got solved %b loc %0d want 1 1", solved1, loc1);
    end
  endtask

  task automatic test_random();
    logic r, i, v;
    logic [1:0] f, t;
    do_reset();
    model_load();
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 99) == 0);
      i = (m_ill || m_sol) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      t = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      drive(r, i, v, f, t);
      if (r || i) model_load();
      else if (v) model_move(int'(f), int'(t));
      checks++;
      if (loc5 !== model_loc() || cnt5 !== 6'(m_cnt) || err5 !== 2'(m_err) ||
          illegal5 !== m_ill || solved5 !== m_sol || ready5 !== !(m_ill || m_sol)) begin
        errors++;
        $display("FAIL random_%0d got loc %h cnt %0d err %0d ill %b sol %b rdy %b want loc %h cnt %0d err %0d ill %b sol %b rdy %b",
                 c, loc5, cnt5, err5, illegal5, solved5, ready5,
                 model_loc(), m_cnt, m_err, m_ill, m_sol, !(m_ill || m_sol));
      end
    end
  endtask

  initial begin
    test_reset();
    test_solve3();
    test_errors();
    test_init();
    test_saturate();
    test_reset_mid();
    test_target1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hanoi_checker.md
HANOI_CHECKER -- requirements
Module: hanoi_checker

Interface
REQ-001 Parameter N_DISKS, default 5, number of disks tracked (legal range 1..8).
REQ-002 Parameter TARGET_PEG, default 3, peg code on which the tower counts as solved.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  synchronous request to reload the start configuration.
REQ-006 move_valid  input  1  a move is presented on from_peg/to_peg.
REQ-007 from_peg  input  2  source peg code: 1, 2 or 3; 0 is invalid.
REQ-008 to_peg  input  2  destination peg code: 1, 2 or 3; 0 is invalid.
REQ-009 move_ready  output  1  checker can accept a move this cycle.
REQ-010 solved  output  1  all disks are on TARGET_PEG.
REQ-011 illegal  output  1  sticky; an illegal move was received.
REQ-012 err_code  output  2  first error: 0 none, 1 bad peg, 2 empty source, 3 larger disk onto smaller.
REQ-013 move_count  output  N_DISKS+1  number of legal moves accepted, saturating.
REQ-014 disk_loc  output  2*N_DISKS  peg code of disk i in bits [2i+1:2i]; disk 0 is the smallest.

Function
REQ-015 A move is accepted on a rising edge when move_valid and move_ready are both 1; move_valid with move_ready low is ignored and never stalls a later move.
REQ-016 The FSM has three states.
- ACTIVE: move_ready=1.
- SOLVED: move_ready=0.
- ERROR: move_ready=0.
REQ-017 Bad-peg check: an accepted move with from_peg=0, to_peg=0 or from_peg=to_peg is illegal with err_code 1.
REQ-018 Empty-source check: an accepted move whose source peg holds no disk is illegal with err_code 2.
REQ-019 Size check: an accepted move whose destination top disk index is lower than the source top disk index is illegal with err_code 3.
REQ-020 When more than one check fails, err_code reports the first failing check in the order 1, 2, 3.
REQ-021 A legal move sets disk_loc of the source top disk to to_peg on the accepting edge, so the new disk_loc is visible the following cycle.
REQ-022 A legal move increments move_count by 1 on the accepting edge; move_count saturates at its all-ones value.
REQ-023 An illegal move leaves disk_loc and move_count unchanged.
REQ-024 An illegal move sets illegal=1 and latches err_code, then the FSM moves ACTIVE->ERROR.
REQ-025 After a legal move, if every disk_loc equals TARGET_PEG, solved=1 from the next cycle and the FSM moves ACTIVE->SOLVED.
REQ-026 A peg's top disk is the lowest-index disk on that peg; a peg with no disk reports empty.
REQ-027 The top-disk lookup is combinational from the current disk_loc and is used in the same cycle as the move.
REQ-028 init=1 in any state sets all disk_loc to 1, move_count=0, illegal=0, err_code=0 and solved=0, and enters ACTIVE.
REQ-029 A move presented in the same cycle as init is discarded.
REQ-030 The ERROR and SOLVED states are left only by init or reset.
REQ-031 When TARGET_PEG=1, solved is not asserted by the start configuration; it is set only after at least one legal move.

Reset
REQ-032 reset has priority over init and over move acceptance.
REQ-033 reset produces the same state as init: all disks on peg 1, outputs 0 except move_ready=1, FSM in ACTIVE.
REQ-034 Asserting reset mid-sequence discards any in-progress move and restores the start configuration on the next edge.

Structure
REQ-035 Shared package hanoi_pkg holds:
- peg code constants PEG_NONE=0, PEG_A=1, PEG_B=2, PEG_C=3;
- the err_code enumeration;
- the FSM state enumeration.
REQ-036 One sub-module, hanoi_top_finder, is instantiated three times, once per peg; it takes disk_loc and a peg code and returns the top-disk index plus an empty flag.
REQ-037 All other logic stays in hanoi_checker; it has no internal stack memories, and disk_loc is the only peg state.

Verification
REQ-038 With N_DISKS=3, reset, then the 7 optimal moves 1->3, 1->2, 3->2, 1->3, 2->1, 2->3, 1->3 one per cycle:
- solved=1 one cycle after the 7th move;
- move_count=7; illegal=0;
- disk_loc all 3; move_ready=0.
REQ-039 After reset, move 1->3 then 1->3: illegal=1, err_code=3, move_count=1, disk_loc[1:0]=3.
REQ-040 After reset, move 2->3: err_code=2, disk_loc unchanged.
REQ-041 After reset, move 0->2: err_code=1.
REQ-042 After reset, move 1->1: err_code=1.
REQ-043 From ERROR, assert init with move_valid=1 (1->3): move ignored; next cycle move_count=0, illegal=0, move_ready=1.
REQ-044 With N_DISKS=5, drive the full 31-move optimal sequence and assert reset after move 10: all disk_loc=1, move_count=0.
REQ-045 With N_DISKS=5, replay the full 31-move sequence after the reset: solved=1, move_count=31.
REQ-046 With move_valid held high while in SOLVED: move_count stays 31 and no state changes.
